// File: rtl/fa16_rev_pkg.sv
// Shared constants and types for the reversible 16-bit adder datapath.
package fa16_rev_pkg;

    localparam int unsigned WIDTH = 16;

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_BWD = 1'b1
    } dir_e;

endpackage

// File: rtl/rev_maj_uma.sv
// One bit of a Cuccaro ripple adder: MAJ followed by UMA when running forward,
// UMA^-1 followed by MAJ^-1 when running backward. Carry ripples upward both ways.
module rev_maj_uma
    import fa16_rev_pkg::*;
(
    input  logic dir,
    input  logic p,     // forward: b, backward: sum
    input  logic a,
    input  logic cin,
    output logic q,     // forward: sum, backward: b
    output logic a_o,
    output logic cout
);

    logic x, y, z, x2, z2;

    always_comb begin
        // First half: MAJ (fwd) or UMA^-1 (bwd). Only the y-wire CNOT differs.
        x = cin ^ a;
        if (dir == DIR_BWD) begin
            y = p ^ cin;
        end else begin
            y = p ^ a;
        end
        z = a ^ (x & y);

        // Second half: UMA (fwd) or MAJ^-1 (bwd); z2 restores a, x2 restores cin.
        z2 = z ^ (x & y);
        x2 = x ^ z2;
        if (dir == DIR_BWD) begin
            q = y ^ z2;
        end else begin
            q = y ^ x2;
        end
    end

    assign a_o  = z2;
    assign cout = z;

endmodule

// File: rtl/fa16_rev_ctrl.sv
// Reversible 16-bit adder with direction select; one shared MAJ/UMA chain feeds
// separately held forward and backward output banks.
module fa16_rev_ctrl
    import fa16_rev_pkg::*;
(
`ifdef USE_POWER_PINS
    inout  wire              VDD,
    inout  wire              VSS,
`endif
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dir,
    input  logic [WIDTH-1:0] f_a,
    input  logic [WIDTH-1:0] f_b,
    input  logic             f_c0_f,
    input  logic             f_z,
    output logic [WIDTH-1:0] f_s,
    output logic [WIDTH-1:0] f_a_b,
    output logic             f_c0_b,
    output logic             f_c15,
    input  logic [WIDTH-1:0] r_s,
    input  logic [WIDTH-1:0] r_a_b,
    input  logic             r_c0_b,
    input  logic             r_c15,
    output logic [WIDTH-1:0] r_a,
    output logic [WIDTH-1:0] r_b,
    output logic             r_c0_f,
    output logic             r_z
);

    logic             bwd;
    logic [WIDTH-1:0] p_in, a_in, q_out, a_out;
    logic [WIDTH:0]   carry;
    logic             anc_in;

    assign bwd      = (dir == DIR_BWD);
    assign p_in     = bwd ? r_s    : f_b;
    assign a_in     = bwd ? r_a_b  : f_a;
    assign carry[0] = bwd ? r_c0_b : f_c0_f;
    assign anc_in   = bwd ? r_c15  : f_z;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        rev_maj_uma u_cell (
            .dir  (dir),
            .p    (p_in[i]),
            .a    (a_in[i]),
            .cin  (carry[i]),
            .q    (q_out[i]),
            .a_o  (a_out[i]),
            .cout (carry[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_s    <= '0;
            f_a_b  <= '0;
            f_c0_b <= 1'b0;
            f_c15  <= 1'b0;
        end else if (!bwd) begin
            f_s    <= q_out;
            f_a_b  <= a_out;
            f_c0_b <= carry[0];
            f_c15  <= anc_in ^ carry[WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_c0_f <= 1'b0;
            r_z    <= 1'b0;
        end else if (bwd) begin
            r_a    <= a_out;
            r_b    <= q_out;
            r_c0_f <= carry[0];
            r_z    <= anc_in ^ carry[WIDTH];
        end
    end

endmodule

// File: tb/tb_fa16_rev_ctrl.sv
// Self-checking bench for fa16_rev_ctrl: directed vectors, reset/hold sequences,
// and random forward->backward round trips against an arithmetic reference.
module tb_fa16_rev_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dir;
    logic [15:0] f_a, f_b, f_s, f_a_b;
    logic        f_c0_f, f_z, f_c0_b, f_c15;
    logic [15:0] r_s, r_a_b, r_a, r_b;
    logic        r_c0_b, r_c15, r_c0_f, r_z;

    int tests  = 0;
    int errors = 0;

    // Expected contents of each output bank, maintained by the bench.
    logic [15:0] ef_s, ef_a_b, er_a, er_b;
    logic        ef_c0_b, ef_c15, er_c0_f, er_z;

    always #5 clk = ~clk;

    fa16_rev_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .dir    (dir),
        .f_a    (f_a),
        .f_b    (f_b),
        .f_c0_f (f_c0_f),
        .f_z    (f_z),
        .f_s    (f_s),
        .f_a_b  (f_a_b),
        .f_c0_b (f_c0_b),
        .f_c15  (f_c15),
        .r_s    (r_s),
        .r_a_b  (r_a_b),
        .r_c0_b (r_c0_b),
        .r_c15  (r_c15),
        .r_a    (r_a),
        .r_b    (r_b),
        .r_c0_f (r_c0_f),
        .r_z    (r_z)
    );

    typedef struct {
        logic        dir;
        logic [15:0] x;   // fwd: a,   bwd: r_s
        logic [15:0] y;   // fwd: b,   bwd: r_a_b
        logic        c;   // fwd: c0,  bwd: r_c0_b
        logic        z;   // fwd: z,   bwd: r_c15
        logic [15:0] e1;  // fwd: f_s, bwd: r_b
        logic [15:0] e2;  // fwd: f_a_b, bwd: r_a
        logic        ec;  // fwd: f_c0_b, bwd: r_c0_f
        logic        ez;  // fwd: f_c15, bwd: r_z
    } vec_t;

    vec_t vecs [10];

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_banks(input string tag);
        chk16({tag, " f_s"}, f_s, ef_s);
        chk16({tag, " f_a_b"}, f_a_b, ef_a_b);
        chk1({tag, " f_c0_b"}, f_c0_b, ef_c0_b);
        chk1({tag, " f_c15"}, f_c15, ef_c15);
        chk16({tag, " r_a"}, r_a, er_a);
        chk16({tag, " r_b"}, r_b, er_b);
        chk1({tag, " r_c0_f"}, r_c0_f, er_c0_f);
        chk1({tag, " r_z"}, r_z, er_z);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain modular arithmetic on 17-bit sums.
    task automatic model_fwd(input logic [15:0] a, input logic [15:0] b, input logic c0,
                             input logic z);
        logic [16:0] sum;
        sum     = {1'b0, a} + {1'b0, b} + {16'd0, c0};
        ef_s    = sum[15:0];
        ef_a_b  = a;
        ef_c0_b = c0;
        ef_c15  = z ^ sum[16];
    endtask

    task automatic model_bwd(input logic [15:0] s, input logic [15:0] a, input logic c0,
                             input logic c15);
        logic [15:0] b;
        logic [16:0] sum;
        b       = s - a - {15'd0, c0};
        sum     = {1'b0, a} + {1'b0, b} + {16'd0, c0};
        er_a    = a;
        er_b    = b;
        er_c0_f = c0;
        er_z    = c15 ^ sum[16];
    endtask

    // Drive one direction; the other direction's inputs get random junk.
    task automatic drive(input logic d, input logic [15:0] x, input logic [15:0] y,
                         input logic c, input logic z);
        dir = d;
        if (d == 1'b0) begin
            f_a = x; f_b = y; f_c0_f = c; f_z = z;
            r_s = 16'($urandom); r_a_b = 16'($urandom);
            r_c0_b = 1'($urandom); r_c15 = 1'($urandom);
        end else begin
            r_s = x; r_a_b = y; r_c0_b = c; r_c15 = z;
            f_a = 16'($urandom); f_b = 16'($urandom);
            f_c0_f = 1'($urandom); f_z = 1'($urandom);
        end
    endtask

    task automatic clear_model();
        ef_s = '0; ef_a_b = '0; ef_c0_b = 1'b0; ef_c15 = 1'b0;
        er_a = '0; er_b = '0; er_c0_f = 1'b0; er_z = 1'b0;
    endtask

    initial begin
        logic [15:0] ra, rb, hs, ha;
        logic        rc, rz, hc, hz;

        vecs[0] = '{1'b0, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 16'h0001, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 16'h1234, 16'h00FF, 1'b1, 1'b1, 16'h1334, 16'h1234, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 16'h0001, 16'hFFFF, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 16'h1334, 16'h1234, 1'b1, 1'b1, 16'h00FF, 16'h1234, 1'b1, 1'b1};
        vecs[8] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
        vecs[9] = '{1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b1};

        rst_n = 1'b0;
        drive(1'b0, 16'hA5A5, 16'h5A5A, 1'b1, 1'b1);
        clear_model();
        #3;
        check_banks("reset");
        step();
        check_banks("reset held");
        #3 rst_n = 1'b1;

        // Directed table; the inactive bank must keep its previous contents.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].dir, vecs[i].x, vecs[i].y, vecs[i].c, vecs[i].z);
            if (vecs[i].dir == 1'b0) begin
                ef_s = vecs[i].e1; ef_a_b = vecs[i].e2;
                ef_c0_b = vecs[i].ec; ef_c15 = vecs[i].ez;
            end else begin
                er_b = vecs[i].e1; er_a = vecs[i].e2;
                er_c0_f = vecs[i].ec; er_z = vecs[i].ez;
            end
            step();
            check_banks($sformatf("vec%0d", i));
        end

        // Forward, then backward on the forward results: f_* hold, r_* round-trip.
        drive(1'b0, 16'h1234, 16'h00FF, 1'b1, 1'b1);
        model_fwd(16'h1234, 16'h00FF, 1'b1, 1'b1);
        step();
        check_banks("rt fwd");
        drive(1'b1, f_s, f_a_b, f_c0_b, f_c15);
        er_a = 16'h1234; er_b = 16'h00FF; er_c0_f = 1'b1; er_z = 1'b1;
        step();
        check_banks("rt bwd");
        step();
        check_banks("rt bwd repeat");

        // Reset asserted away from the edge clears both banks immediately.
        drive(1'b0, 16'h4321, 16'h1111, 1'b0, 1'b1);
        model_fwd(16'h4321, 16'h1111, 1'b0, 1'b1);
        step();
        check_banks("pre reset");
        #2 rst_n = 1'b0;
        #1;
        clear_model();
        check_banks("async reset");
        step();
        check_banks("reset discards");
        #2 rst_n = 1'b1;
        #1;
        check_banks("after release");
        model_fwd(16'h4321, 16'h1111, 1'b0, 1'b1);
        step();
        check_banks("reload");

        // Random round trips with dir toggling every cycle.
        for (int i = 0; i < 100; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom);  rz = 1'($urandom);
            if (i % 10 == 0) ra = 16'hFFFF;
            drive(1'b0, ra, rb, rc, rz);
            model_fwd(ra, rb, rc, rz);
            step();
            check_banks($sformatf("rnd%0d fwd", i));
            hs = f_s; ha = f_a_b; hc = f_c0_b; hz = f_c15;
            drive(1'b1, hs, ha, hc, hz);
            model_bwd(ef_s, ef_a_b, ef_c0_b, ef_c15);
            step();
            chk16($sformatf("rnd%0d rt a", i), r_a, ra);
            chk16($sformatf("rnd%0d rt b", i), r_b, rb);
            chk1($sformatf("rnd%0d rt c0", i), r_c0_f, rc);
            chk1($sformatf("rnd%0d rt z", i), r_z, rz);
            check_banks($sformatf("rnd%0d bwd", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
